// File: rtl/flasher_pkg.sv
// -----------------------------------------------------------------------------
// flasher_pkg
// Shared definitions for the flasher front end: the flick conditioner FSM
// state encoding and the default debounce / synchronizer depths.
// -----------------------------------------------------------------------------
package flasher_pkg;

   // Encoding is visible on state_dbg, so the values are fixed.
   typedef enum logic [1:0] {
      LOW      = 2'd0,
      CHK_HIGH = 2'd1,
      HIGH     = 2'd2,
      CHK_LOW  = 2'd3
   } flick_state_t;

   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;
   localparam int unsigned SYNC_STAGES_DEFAULT     = 2;

endpackage : flasher_pkg

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Multi-flop synchronizer for a single asynchronous input.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset, clears every stage to 0
//   i_d     : asynchronous input
//   o_q     : synchronized output (last stage)
// -----------------------------------------------------------------------------
module sync_ff #(
   parameter int unsigned DEPTH = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [DEPTH-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[DEPTH-2:0], i_d};
      end
   end

   assign o_q = r_sync[DEPTH-1];

endmodule : sync_ff

// File: rtl/flick_conditioner.sv
// -----------------------------------------------------------------------------
// flick_conditioner
// Synchronizes and debounces the flick switch, then produces a clean level,
// a one-cycle rising-edge strobe and a sticky request for the consumer.
//   clk         : system clock (rising edge)
//   rst_n       : asynchronous active-low reset
//   flick_raw   : asynchronous, bouncing switch input
//   flick_ack   : consumer acknowledge, clears flick_req
//   flick       : debounced level
//   flick_pulse : one-cycle strobe per accepted rising edge
//   flick_req   : sticky request, held until flick_ack
//   state_dbg   : current FSM state encoding
// -----------------------------------------------------------------------------
module flick_conditioner
   import flasher_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flick_raw,
   input  logic       flick_ack,
   output logic       flick,
   output logic       flick_pulse,
   output logic       flick_req,
   output logic [1:0] state_dbg
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             w_s;
   flick_state_t     r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_flick;
   logic             r_pulse;
   logic             r_req;

   sync_ff #(
      .DEPTH (SYNC_STAGES)
   ) u_sync (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_d     (flick_raw),
      .o_q     (w_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= LOW;
         r_cnt   <= '0;
         r_flick <= 1'b0;
         r_pulse <= 1'b0;
         r_req   <= 1'b0;
      end else begin
         r_pulse <= 1'b0;
         // A pulse in the same cycle as an ack keeps the request set.
         r_req   <= r_pulse | (r_req & ~flick_ack);
         unique case (r_state)
            LOW: begin
               if (w_s) begin
                  r_state <= CHK_HIGH;
                  r_cnt   <= '0;
               end
            end
            CHK_HIGH: begin
               if (!w_s) begin
                  r_state <= LOW;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= HIGH;
                  r_cnt   <= '0;
                  r_flick <= 1'b1;
                  r_pulse <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            HIGH: begin
               if (!w_s) begin
                  r_state <= CHK_LOW;
                  r_cnt   <= '0;
               end
            end
            CHK_LOW: begin
               if (w_s) begin
                  r_state <= HIGH;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= LOW;
                  r_cnt   <= '0;
                  r_flick <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= LOW;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign flick       = r_flick;
   assign flick_pulse = r_pulse;
   assign flick_req   = r_req;
   assign state_dbg   = r_state;

endmodule : flick_conditioner

// File: tb/tb_flick_conditioner.sv
// -----------------------------------------------------------------------------
// tb_flick_conditioner
// Self-checking bench for flick_conditioner (DEBOUNCE_CYCLES=16, SYNC_STAGES=2).
// A run-length reference model predicts every output each cycle; table
// segments and hand-written sequences check fixed expectations on top.
// -----------------------------------------------------------------------------
module tb_flick_conditioner;

   localparam int DEB = 16;
   localparam int SYN = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flick_raw = 1'b0;
   logic       flick_ack = 1'b0;
   logic       flick;
   logic       flick_pulse;
   logic       flick_req;
   logic [1:0] state_dbg;

   always #5 clk = ~clk;

   flick_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .SYNC_STAGES     (SYN)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flick_raw   (flick_raw),
      .flick_ack   (flick_ack),
      .flick       (flick),
      .flick_pulse (flick_pulse),
      .flick_req   (flick_req),
      .state_dbg   (state_dbg)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: s is the raw input delayed by SYN samples; the accepted
   // level flips once s has disagreed with it for DEB+1 consecutive samples.
   bit m_hist[SYN];
   bit m_level;
   int m_run;
   bit m_pulse;
   bit m_req;
   int pulses_seen;

   task automatic model_reset();
      for (int i = 0; i < SYN; i++) m_hist[i] = 1'b0;
      m_level = 1'b0;
      m_run   = 0;
      m_pulse = 1'b0;
      m_req   = 1'b0;
   endtask

   function automatic int model_state();
      if (m_level) return (m_run > 0) ? 3 : 2;
      else         return (m_run > 0) ? 1 : 0;
   endfunction

   // Called at a negedge; drives inputs, advances one clock, checks, and
   // returns at the next negedge.
   task automatic step(input bit raw, input bit ack);
      bit s;
      bit new_req;
      flick_raw = raw;
      flick_ack = ack;
      @(posedge clk);
      s = m_hist[SYN-1];
      for (int i = SYN - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = raw;
      new_req = m_pulse | (m_req & !ack);
      m_pulse = 1'b0;
      if (s == m_level) begin
         m_run = 0;
      end else begin
         m_run++;
         if (m_run == DEB + 1) begin
            m_level = s;
            m_run   = 0;
            m_pulse = s;
         end
      end
      m_req = new_req;
      #1;
      check("model_flick", int'(flick), int'(m_level));
      check("model_pulse", int'(flick_pulse), int'(m_pulse));
      check("model_req", int'(flick_req), int'(m_req));
      check("model_state", int'(state_dbg), model_state());
      if (flick_pulse) pulses_seen++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      flick_raw = 1'b0;
      flick_ack = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit   raw;
      bit   ack;
      int   n;
      bit   e_flick;
      bit   e_req;
      int   e_state;
      int   e_pulses;
   } vec_t;

   vec_t tbl[25];

   initial begin
      int first_pulse;
      int burst_val;
      int burst_len;

      tbl[0]  = '{raw:0, ack:0, n:100, e_flick:0, e_req:0, e_state:0, e_pulses:0};
      tbl[1]  = '{raw:1, ack:0, n:18,  e_flick:0, e_req:0, e_state:1, e_pulses:0};
      tbl[2]  = '{raw:1, ack:0, n:1,   e_flick:1, e_req:0, e_state:2, e_pulses:1};
      tbl[3]  = '{raw:1, ack:0, n:1,   e_flick:1, e_req:1, e_state:2, e_pulses:0};
      tbl[4]  = '{raw:1, ack:0, n:20,  e_flick:1, e_req:1, e_state:2, e_pulses:0};
      tbl[5]  = '{raw:1, ack:1, n:1,   e_flick:1, e_req:0, e_state:2, e_pulses:0};
      tbl[6]  = '{raw:0, ack:0, n:2,   e_flick:1, e_req:0, e_state:2, e_pulses:0};
      tbl[7]  = '{raw:0, ack:0, n:1,   e_flick:1, e_req:0, e_state:3, e_pulses:0};
      tbl[8]  = '{raw:0, ack:0, n:15,  e_flick:1, e_req:0, e_state:3, e_pulses:0};
      tbl[9]  = '{raw:0, ack:0, n:1,   e_flick:0, e_req:0, e_state:0, e_pulses:0};
      tbl[10] = '{raw:1, ack:0, n:10,  e_flick:0, e_req:0, e_state:1, e_pulses:0};
      tbl[11] = '{raw:0, ack:0, n:30,  e_flick:0, e_req:0, e_state:0, e_pulses:0};
      tbl[12] = '{raw:1, ack:0, n:19,  e_flick:1, e_req:0, e_state:2, e_pulses:1};
      tbl[13] = '{raw:1, ack:1, n:1,   e_flick:1, e_req:1, e_state:2, e_pulses:0};
      tbl[14] = '{raw:1, ack:0, n:5,   e_flick:1, e_req:1, e_state:2, e_pulses:0};
      tbl[15] = '{raw:1, ack:1, n:1,   e_flick:1, e_req:0, e_state:2, e_pulses:0};
      tbl[16] = '{raw:1, ack:1, n:3,   e_flick:1, e_req:0, e_state:2, e_pulses:0};
      tbl[17] = '{raw:0, ack:0, n:25,  e_flick:0, e_req:0, e_state:0, e_pulses:0};
      tbl[18] = '{raw:1, ack:0, n:19,  e_flick:1, e_req:0, e_state:2, e_pulses:1};
      tbl[19] = '{raw:1, ack:0, n:2,   e_flick:1, e_req:1, e_state:2, e_pulses:0};
      tbl[20] = '{raw:0, ack:0, n:25,  e_flick:0, e_req:1, e_state:0, e_pulses:0};
      tbl[21] = '{raw:1, ack:0, n:19,  e_flick:1, e_req:1, e_state:2, e_pulses:1};
      tbl[22] = '{raw:1, ack:1, n:1,   e_flick:1, e_req:1, e_state:2, e_pulses:0};
      tbl[23] = '{raw:1, ack:1, n:1,   e_flick:1, e_req:0, e_state:2, e_pulses:0};
      tbl[24] = '{raw:0, ack:0, n:25,  e_flick:0, e_req:0, e_state:0, e_pulses:0};

      // Reset state, asynchronous: outputs must be zero before any clock.
      rst_n = 1'b0;
      model_reset();
      #2;
      check("reset_flick", int'(flick), 0);
      check("reset_pulse", int'(flick_pulse), 0);
      check("reset_req", int'(flick_req), 0);
      check("reset_state", int'(state_dbg), 0);
      do_reset();

      // Table segments, checked at the end of each segment.
      for (int v = 0; v < 25; v++) begin
         pulses_seen = 0;
         for (int c = 0; c < tbl[v].n; c++) step(tbl[v].raw, tbl[v].ack);
         check($sformatf("tbl%0d_flick", v), int'(flick), int'(tbl[v].e_flick));
         check($sformatf("tbl%0d_req", v), int'(flick_req), int'(tbl[v].e_req));
         check($sformatf("tbl%0d_state", v), int'(state_dbg), tbl[v].e_state);
         check($sformatf("tbl%0d_pulses", v), pulses_seen, tbl[v].e_pulses);
      end

      // Bounce 1,0,1,0 for 5 cycles each, then steady high.
      pulses_seen = 0;
      first_pulse = -1;
      for (int ph = 0; ph < 4; ph++)
         for (int c = 0; c < 5; c++) step(bit'((ph % 2) == 0), 1'b0);
      check("bounce_no_pulse", pulses_seen, 0);
      for (int c = 0; c < 30; c++) begin
         step(1'b1, 1'b0);
         if (flick_pulse && first_pulse < 0) first_pulse = c + 1;
      end
      check("bounce_pulses", pulses_seen, 1);
      check("bounce_latency", first_pulse, SYN + DEB + 1);
      for (int c = 0; c < 25; c++) step(1'b0, 1'b1);

      // Reset in CHK_HIGH with counter=8 (11 clocks after the raw rise).
      for (int c = 0; c < 11; c++) step(1'b1, 1'b0);
      check("pre_rst_state", int'(state_dbg), 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_flick", int'(flick), 0);
      check("midrst_pulse", int'(flick_pulse), 0);
      check("midrst_req", int'(flick_req), 0);
      check("midrst_state", int'(state_dbg), 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < SYN + DEB; c++) step(1'b1, 1'b0);
      check("postrst_not_yet", int'(flick), 0);
      step(1'b1, 1'b0);
      check("postrst_flick", int'(flick), 1);
      check("postrst_pulse", int'(flick_pulse), 1);
      for (int c = 0; c < 25; c++) step(1'b0, 1'b1);

      // Random bursts with sparse random acknowledges.
      for (int b = 0; b < 200; b++) begin
         burst_val = int'($urandom_range(0, 1));
         burst_len = int'($urandom_range(1, 40));
         for (int c = 0; c < burst_len; c++)
            step(bit'(burst_val), bit'($urandom_range(0, 7) == 0));
      end

      // Long steady high: one acceptance at most, then no further pulses.
      for (int c = 0; c < 40; c++) step(1'b1, 1'b0);
      check("steady_level", int'(flick), 1);
      pulses_seen = 0;
      for (int c = 0; c < 10000; c++) step(1'b1, bit'($urandom_range(0, 15) == 0));
      check("steady_no_pulse", pulses_seen, 0);
      check("steady_state", int'(state_dbg), 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_flick_conditioner
